// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: decodes {opcode, rsvd, len_lo, len_hi, payload} packets into echo bytes or 32-bit ALU operands.
// Operand valid 1 cycle after its 4th byte, held until opnd_ready_i; echo is combinational; UART_PKT_PARSER_TIMEOUT_EN adds idle abort.
module uart_pkt_parser #(
  parameter int TimeoutCycles = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i,
  output logic [31:0] opnd_data_o,
  output logic [1:0]  opnd_op_o,
  output logic        opnd_first_o,
  output logic        opnd_last_o,
  output logic        opnd_valid_o,
  input  logic        opnd_ready_i,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_ECHO,
    S_OPND,
    S_DRAIN
  } state_t;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  state_t      state;
  logic [7:0]  opcode;
  logic [7:0]  len_lo;
  logic [15:0] remaining;
  logic [23:0] shift;
  logic [1:0]  byte_cnt;
  logic        first_pend;
  logic        rdy_q;
  logic        accept;
  logic [15:0] len_w;
  logic        alu_len_ok;
  logic        tmo_fire;

  // rdy_q keeps ready low for the first cycle after reset release
  assign rx_ready_o   = (state == S_ECHO) ? echo_ready_i : (rdy_q && !opnd_valid_o);
  assign accept       = rx_valid_i && rx_ready_o;
  assign echo_data_o  = rx_data_i;
  assign echo_valid_o = (state == S_ECHO) && rx_valid_i;
  assign len_w        = {rx_data_i, len_lo};
  assign alu_len_ok   = ((opcode == OP_ADD || opcode == OP_MUL) && len_w != 16'd0 && len_w[1:0] == 2'b00)
                     || (opcode == OP_DIV && len_w == 16'd8);

`ifdef UART_PKT_PARSER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        stalled;

  // waiting on a downstream consumer is not an idle line
  assign stalled  = opnd_valid_o || (state == S_ECHO && rx_valid_i && !echo_ready_i);
  assign tmo_fire = (state != S_OPCODE) && !accept && !stalled
                 && (tmo_cnt == 32'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (accept || stalled || state == S_OPCODE || tmo_fire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TimeoutCycles);
  assign tmo_fire       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_OPCODE;
      opcode       <= '0;
      len_lo       <= '0;
      remaining    <= '0;
      shift        <= '0;
      byte_cnt     <= '0;
      first_pend   <= 1'b0;
      rdy_q        <= 1'b0;
      opnd_data_o  <= '0;
      opnd_op_o    <= '0;
      opnd_first_o <= 1'b0;
      opnd_last_o  <= 1'b0;
      opnd_valid_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      err_o <= 1'b0;
      if (opnd_valid_o && opnd_ready_i) begin
        opnd_valid_o <= 1'b0;
      end

      if (tmo_fire) begin
        state        <= S_OPCODE;
        remaining    <= '0;
        shift        <= '0;
        byte_cnt     <= '0;
        opnd_valid_o <= 1'b0;
        err_o        <= 1'b1;
      end else begin
        case (state)
          S_OPCODE: begin
            if (accept) begin
              opcode <= rx_data_i;
              state  <= S_RSVD;
            end
          end
          S_RSVD: begin
            if (accept) begin
              state <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (accept) begin
              len_lo <= rx_data_i;
              state  <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (accept) begin
              remaining  <= len_w;
              byte_cnt   <= '0;
              first_pend <= 1'b1;
              if (opcode == OP_ECHO) begin
                state <= (len_w == 16'd0) ? S_OPCODE : S_ECHO;
              end else if (alu_len_ok) begin
                state <= S_OPND;
              end else begin
                err_o <= 1'b1;
                state <= (len_w == 16'd0) ? S_OPCODE : S_DRAIN;
              end
            end
          end
          S_ECHO, S_DRAIN: begin
            if (accept) begin
              remaining <= remaining - 16'd1;
              if (remaining == 16'd1) begin
                state <= S_OPCODE;
              end
            end
          end
          S_OPND: begin
            if (accept) begin
              remaining <= remaining - 16'd1;
              byte_cnt  <= byte_cnt + 2'd1;
              shift     <= {rx_data_i, shift[23:8]};
              if (byte_cnt == 2'd3) begin
                opnd_data_o  <= {rx_data_i, shift};
                opnd_op_o    <= opcode[1:0];
                opnd_first_o <= first_pend;
                opnd_last_o  <= (remaining == 16'd1);
                opnd_valid_o <= 1'b1;
                first_pend   <= 1'b0;
              end
            end else if (opnd_valid_o && opnd_ready_i && opnd_last_o) begin
              state <= S_OPCODE;
            end
          end
          default: state <= S_OPCODE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser; the timeout section follows UART_PKT_PARSER_TIMEOUT_EN (TimeoutCycles=100).
module tb_uart_pkt_parser;

  logic        clk_i;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  echo_data_o;
  logic        echo_valid_o;
  logic        echo_ready_i;
  logic [31:0] opnd_data_o;
  logic [1:0]  opnd_op_o;
  logic        opnd_first_o;
  logic        opnd_last_o;
  logic        opnd_valid_o;
  logic        opnd_ready_i;
  logic        err_o;

  uart_pkt_parser #(.TimeoutCycles(100)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .echo_data_o  (echo_data_o),
    .echo_valid_o (echo_valid_o),
    .echo_ready_i (echo_ready_i),
    .opnd_data_o  (opnd_data_o),
    .opnd_op_o    (opnd_op_o),
    .opnd_first_o (opnd_first_o),
    .opnd_last_o  (opnd_last_o),
    .opnd_valid_o (opnd_valid_o),
    .opnd_ready_i (opnd_ready_i),
    .err_o        (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int overlap_cnt = 0;
  logic [7:0]  echo_q[$];
  logic [35:0] opnd_q[$];
  logic [7:0]  tx_q[$];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_opnd(input string tag, input int idx, input logic [35:0] exp);
    logic [35:0] got;
    got = (idx < opnd_q.size()) ? opnd_q[idx] : 'x;
    check(tag, 64'(got), 64'(exp));
  endtask

  task automatic check_echo(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] got;
    got = (idx < echo_q.size()) ? echo_q[idx] : 'x;
    check(tag, 64'(got), 64'(exp));
  endtask

  function automatic logic [39:0] out_vec();
    return {rx_ready_o, echo_valid_o, opnd_valid_o, opnd_data_o, opnd_op_o,
            opnd_first_o, opnd_last_o, err_o};
  endfunction

  // Records transfers that complete on the following rising edge.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni) begin
        if (echo_valid_o && echo_ready_i) echo_q.push_back(echo_data_o);
        if (opnd_valid_o && opnd_ready_i)
          opnd_q.push_back({opnd_op_o, opnd_first_o, opnd_last_o, opnd_data_o});
        if (err_o) err_cnt++;
        if (err_o && opnd_valid_o) overlap_cnt++;
      end
    end
  end

  // Called at a falling edge; returns at a falling edge.
  task automatic send(input logic [7:0] b);
    bit done;
    done       = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (rx_ready_o) begin
        @(posedge clk_i);
        done = 1'b1;
      end
      @(negedge clk_i);
    end
    rx_valid_i = 1'b0;
    if (!done) check("send_timeout", 64'(b), 64'hFFFF);
  endtask

  task automatic send_all();
    foreach (tx_q[i]) send(tx_q[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic clear_logs();
    echo_q.delete();
    opnd_q.delete();
    err_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #2;
    check("rst_outputs", 64'(out_vec()), 64'd0);
    idle(2);
    rst_ni = 1'b1;
    #1;
    check("rst_rdy_first_cycle", 64'(rx_ready_o), 64'd0);
    @(negedge clk_i);
    #1;
    check("rst_rdy_rises", 64'(rx_ready_o), 64'd1);
    @(negedge clk_i);
  endtask

  initial begin
    bit seen;
    int wait_n;
    rst_ni       = 1'b1;
    rx_data_i    = 8'h00;
    rx_valid_i   = 1'b0;
    echo_ready_i = 1'b1;
    opnd_ready_i = 1'b1;
    #1;
    do_reset();

    // ECHO of two bytes
    clear_logs();
    tx_q = '{8'hEC, 8'h00, 8'h02, 8'h00, 8'h68, 8'h69};
    send_all();
    idle(3);
    check("echo_count", 64'(echo_q.size()), 64'd2);
    check_echo("echo_b0", 0, 8'h68);
    check_echo("echo_b1", 1, 8'h69);
    check("echo_no_opnd", 64'(opnd_q.size()), 64'd0);
    check("echo_no_err", 64'(err_cnt), 64'd0);

    // MUL with two operands
    clear_logs();
    tx_q = '{8'hA1, 8'h00, 8'h08, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00,
             8'h06, 8'h00, 8'h00, 8'h00};
    send_all();
    idle(3);
    check("mul_count", 64'(opnd_q.size()), 64'd2);
    check_opnd("mul_op0", 0, {2'b01, 1'b1, 1'b0, 32'h0000_0004});
    check_opnd("mul_op1", 1, {2'b01, 1'b0, 1'b1, 32'h0000_0006});

    // DIV with the first operand held off for five cycles
    clear_logs();
    opnd_ready_i = 1'b0;
    tx_q = '{8'hA2, 8'h00, 8'h08, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00,
             8'h05, 8'h00, 8'h00, 8'h00};
    fork
      send_all();
      begin
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk_i);
          #2;
          if (opnd_valid_o) seen = 1'b1;
        end
        check("div_valid_seen", 64'(seen), 64'd1);
        for (int k = 0; k < 5; k++) begin
          check("div_hold_vld", 64'(opnd_valid_o), 64'd1);
          check("div_hold_dat", 64'(opnd_data_o), 64'h0000_000F);
          check("div_hold_rdy", 64'(rx_ready_o), 64'd0);
          @(negedge clk_i);
          if (k < 4) #2;
        end
        opnd_ready_i = 1'b1;
      end
    join
    idle(3);
    check("div_count", 64'(opnd_q.size()), 64'd2);
    check_opnd("div_op0", 0, {2'b10, 1'b1, 1'b0, 32'h0000_000F});
    check_opnd("div_op1", 1, {2'b10, 1'b0, 1'b1, 32'h0000_0005});
    check("div_no_err", 64'(err_cnt), 64'd0);

    // DIV with length 4 is drained with an error, then ADD parses normally
    clear_logs();
    tx_q = '{8'hA2, 8'h00, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_all();
    idle(2);
    check("bad_div_err", 64'(err_cnt), 64'd1);
    check("bad_div_no_opnd", 64'(opnd_q.size()), 64'd0);
    check("bad_div_echo", 64'(echo_q.size()), 64'd0);
    tx_q = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
             8'h03, 8'h00, 8'h00, 8'h00};
    send_all();
    idle(3);
    check("add_count", 64'(opnd_q.size()), 64'd2);
    check_opnd("add_op0", 0, {2'b00, 1'b1, 1'b0, 32'h0000_0002});
    check_opnd("add_op1", 1, {2'b00, 1'b0, 1'b1, 32'h0000_0003});
    check("add_err_unchanged", 64'(err_cnt), 64'd1);

    // Zero-length cases and an unknown opcode
    clear_logs();
    tx_q = '{8'hA0, 8'h00, 8'h00, 8'h00};
    send_all();
    idle(2);
    check("alu_len0_err", 64'(err_cnt), 64'd1);
    tx_q = '{8'hEC, 8'h00, 8'h00, 8'h00};
    send_all();
    idle(2);
    check("echo_len0_err", 64'(err_cnt), 64'd1);
    check("echo_len0_none", 64'(echo_q.size()), 64'd0);
    tx_q = '{8'h55, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hEC, 8'h00, 8'h01, 8'h00, 8'h77};
    send_all();
    idle(2);
    check("unknown_err", 64'(err_cnt), 64'd2);
    check("unknown_echo_count", 64'(echo_q.size()), 64'd1);
    check_echo("unknown_then_echo", 0, 8'h77);

    // Reset in the middle of an ADD operand
    clear_logs();
    tx_q = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h02};
    send_all();
    do_reset();
    tx_q = '{8'hEC, 8'h00, 8'h01, 8'h00, 8'h5A};
    send_all();
    idle(3);
    check("post_rst_echo_count", 64'(echo_q.size()), 64'd1);
    check_echo("post_rst_echo", 0, 8'h5A);
    check("post_rst_no_opnd", 64'(opnd_q.size()), 64'd0);
    check("post_rst_no_err", 64'(err_cnt), 64'd0);

    // Silence mid-packet
    clear_logs();
    tx_q = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h02};
    send_all();
`ifdef UART_PKT_PARSER_TIMEOUT_EN
    seen   = 1'b0;
    wait_n = 0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      @(negedge clk_i);
      #2;
      if (err_o) begin
        seen   = 1'b1;
        wait_n = i;
      end
    end
    check("tmo_err_seen", 64'(seen), 64'd1);
    check("tmo_err_cycle", 64'(wait_n), 64'd100);
    check("tmo_no_opnd", 64'(opnd_valid_o), 64'd0);
    @(negedge clk_i);
    tx_q = '{8'hEC, 8'h00, 8'h01, 8'h00, 8'h33};
    send_all();
    idle(2);
    check_echo("tmo_then_echo", 0, 8'h33);
`else
    idle(200);
    check("no_tmo_err", 64'(err_cnt), 64'd0);
    check("no_tmo_opnd", 64'(opnd_valid_o), 64'd0);
    check("no_tmo_rdy", 64'(rx_ready_o), 64'd1);
    do_reset();
`endif

    check("err_opnd_overlap", 64'(overlap_cnt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/uart_pkt_parser.md
Name: uart_pkt_parser

Overview:
- Sits between the UART receiver and the ALU datapath in the UART ALU design.
- Consumes the received byte stream and decodes packets of the form: opcode, reserved, length LSB, length MSB, then payload.
- ECHO payload bytes go to the transmit path.
- ADD/MUL/DIV payloads are assembled into 32-bit little-endian operands and streamed to the ALU with first/last markers.

Parameters:
- TimeoutCycles, default 1000000: inter-byte idle cycles before a mid-packet abort. Used only with the optional feature.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- rx_data_i  in  8  byte from UART receiver
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  parser accepts byte (transfer when valid & ready)
- echo_data_o  out  8  echo byte to TX path
- echo_valid_o  out  1  echo byte valid
- echo_ready_i  in  1  TX path accepts echo byte
- opnd_data_o  out  32  assembled operand, little-endian
- opnd_op_o  out  2  00 ADD, 01 MUL, 10 DIV
- opnd_first_o  out  1  first operand of packet
- opnd_last_o  out  1  last operand of packet
- opnd_valid_o  out  1  operand valid
- opnd_ready_i  in  1  ALU accepts operand
- err_o  out  1  one-cycle pulse on a malformed or aborted packet

Behaviour:
- Opcodes: 0xEC ECHO, 0xA0 ADD, 0xA1 MUL, 0xA2 DIV. Any other value is unknown.
- Length: 16-bit {LEN_HI, LEN_LO}. It counts payload bytes only.
- Reset (async on rst_ni low, applies mid-packet too):
  - State goes to OPCODE; all counters clear.
  - rx_ready_o=0, echo_valid_o=0, opnd_valid_o=0, opnd_data_o=0, opnd_op_o=0, opnd_first_o=0, opnd_last_o=0, err_o=0.
  - rx_ready_o rises the first cycle after reset release.
- States:
  - OPCODE -> RSVD: on accept; latch opcode.
  - RSVD -> LEN_LO: on accept; reserved byte value ignored.
  - LEN_LO -> LEN_HI: on accept.
  - LEN_HI: on accept, latch length into remaining counter, then branch:
    - length 0 with ECHO -> OPCODE; nothing emitted.
    - ECHO with length > 0 -> ECHO.
    - ADD/MUL with length a nonzero multiple of 4 -> OPND.
    - DIV with length exactly 8 -> OPND.
    - Otherwise, including unknown opcode and ALU length 0 -> DRAIN with err_o pulse; length 0 goes straight to OPCODE with err_o pulse.
  - ECHO: combinational pass-through.
    - echo_data_o=rx_data_i, echo_valid_o=rx_valid_i, rx_ready_o=echo_ready_i.
    - Decrement remaining on each transfer; after the last byte -> OPCODE.
  - OPND: accept bytes into a shift register, byte 0 = bits 7:0.
    - On the 4th byte, register the operand and assert opnd_valid_o the next cycle.
    - opnd_first_o is set for the first operand of the packet; opnd_last_o is set when remaining reaches 0.
    - rx_ready_o=0 while opnd_valid_o=1.
    - opnd_valid_o holds, with data stable, until opnd_ready_i.
    - After the last operand handshake -> OPCODE; otherwise keep collecting.
  - DRAIN: rx_ready_o=1; discard remaining bytes, then -> OPCODE.
- rx_ready_o is 1 in OPCODE/RSVD/LEN_LO/LEN_HI/DRAIN, and 0 in the cycle after reset.
- No throughput requirement. Minimum operand latency: 1 cycle from 4th-byte accept to opnd_valid_o.
- err_o never overlaps with opnd_valid_o.

Optional Feature:
- Macro: UART_PKT_PARSER_TIMEOUT_EN.
- With it: a counter clears on every accepted byte and counts while the state is not OPCODE and no byte is accepted.
  - At TimeoutCycles: state -> OPCODE, the partial operand is discarded, any pending opnd_valid_o is dropped, and err_o pulses.
  - No timeout runs while stalled by opnd_ready_i=0 or echo_ready_i=0 with rx_valid_i=1.
- Without it: no counter; the parser waits indefinitely for bytes.

Test Plan:
- ECHO: bytes EC 00 02 00 68 69, echo_ready_i=1 -> echo_data_o 0x68 then 0x69, no operand, back to OPCODE.
- MUL: A1 00 08 00 04 00 00 00 06 00 00 00 -> operands 0x00000004 (first=1, last=0) and 0x00000006 (first=0, last=1), op=01.
- DIV with backpressure: A2 00 08 00 0F 00 00 00 05 00 00 00, opnd_ready_i low for 5 cycles on the first operand -> 0x0000000F held stable, rx_ready_o=0 meanwhile, then 0x00000005 with last=1, op=10.
- Malformed:
  - A2 00 04 00 + 4 bytes -> err_o pulse, 4 bytes drained, no operand.
  - Then A0 00 08 00 02..00 03..00 -> 0x2, 0x3, op=00.
- Reset mid-packet: assert rst_ni low after A0 00 08 00 02 -> all outputs at reset values; the following ECHO packet parses correctly.
- Timeout (macro defined, TimeoutCycles=100): A0 00 08 00 02 then silence -> err_o at cycle 100, state OPCODE; with macro undefined -> no err_o.
